// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO test path (writer and reader):
// state encoding, default settling delay and the LFSR pattern generator.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int DEFAULT_DELAY_CYC = 10;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fifo_write_if.sv
// Write-port bundle between the write controller (master) and the FIFO side.
interface fifo_write_if #(
  parameter int DATA_W      = 8,
  parameter int BURST_CNT_W = 16
);
  logic                   almost_empty;
  logic                   almost_full;
  logic                   full;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_wdata;
  logic [BURST_CNT_W-1:0] wr_burst_cnt;
  logic                   wr_busy;

  modport master (
    input  almost_empty, almost_full, full,
    output fifo_wr_en, fifo_wdata, wr_burst_cnt, wr_busy
  );

  modport slave (
    output almost_empty, almost_full, full,
    input  fifo_wr_en, fifo_wdata, wr_burst_cnt, wr_busy
  );
endinterface

// File: rtl/fifo_edge_det.sv
// Two-flop edge detector on a same-domain flag, selectable rising or falling.
// Output is masked until both history flops hold real samples after reset.
module fifo_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_o
);

  logic       d0_q, d0_d;
  logic       d1_q, d1_d;
  logic [1:0] vld_q, vld_d;

  always_comb begin
    d0_d  = din;
    d1_d  = d0_q;
    vld_d = {vld_q[0], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q  <= 1'b0;
      d1_q  <= 1'b0;
      vld_q <= 2'b00;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      vld_q <= vld_d;
    end
  end

  // A level already present at reset release must not look like an edge.
  assign edge_o = vld_q[1] & (RISING ? (d0_q & ~d1_q) : (~d0_q & d1_q));

endmodule

// File: rtl/fifo_write.sv
// FIFO write controller: on an almost_empty rising edge, wait DELAY_CYC cycles,
// then write a data pattern until almost_full/full. FIFO_WR_LFSR_EN selects LFSR data.
module fifo_write
  import fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DELAY_CYC   = DEFAULT_DELAY_CYC,
  parameter int BURST_CNT_W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  fifo_write_if.master wr
);

  if (DELAY_CYC < 1 || DELAY_CYC > 255) begin : g_bad_delay
    $error("fifo_write: DELAY_CYC must be in 1..255");
  end

`ifdef FIFO_WR_LFSR_EN
  if (DATA_W != 8) begin : g_bad_width
    $error("fifo_write: FIFO_WR_LFSR_EN requires DATA_W == 8");
  end
  localparam logic [DATA_W-1:0] WDATA_RST = DATA_W'(LFSR_SEED);
`else
  localparam logic [DATA_W-1:0] WDATA_RST = '0;
`endif

  localparam logic [7:0] DELAY_LAST = 8'(DELAY_CYC - 1);

  state_e                 state_q, state_d;
  logic [7:0]             dly_cnt_q, dly_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d, wdata_next;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   busy_q, busy_d;
  logic                   ae_rise;
  logic                   wr_accept;

  fifo_edge_det #(.RISING(1'b1)) u_ae_edge (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .din    (wr.almost_empty),
    .edge_o (ae_rise)
  );

  assign wr_accept = wr_en_q & ~wr.full;

  always_comb begin
`ifdef FIFO_WR_LFSR_EN
    wdata_next = DATA_W'(lfsr_next(8'(wdata_q)));
`else
    wdata_next = wdata_q + DATA_W'(1);
`endif
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    wr_en_d     = wr_en_q;
    burst_cnt_d = burst_cnt_q;
    wdata_d     = wr_accept ? wdata_next : wdata_q;

    case (state_q)
      ST_IDLE: begin
        wr_en_d   = 1'b0;
        dly_cnt_d = 8'd0;
        if (ae_rise) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (dly_cnt_q == DELAY_LAST) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          dly_cnt_d = 8'd0;
        end else begin
          dly_cnt_d = dly_cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        if (wr.almost_full || wr.full) begin
          state_d     = ST_IDLE;
          wr_en_d     = 1'b0;
          burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
        end else begin
          wr_en_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        wr_en_d   = 1'b0;
        dly_cnt_d = 8'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      dly_cnt_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      wdata_q     <= WDATA_RST;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign wr.fifo_wr_en   = wr_en_q;
  assign wr.fifo_wdata   = wdata_q;
  assign wr.wr_burst_cnt = burst_cnt_q;
  assign wr.wr_busy      = busy_q;

endmodule

// File: tb/tb_fifo_write.sv
// Scoreboard bench for fifo_write: stimulus queues expected write data, a
// negedge monitor pops and compares on every accepted write.
module tb_fifo_write;

  localparam int DATA_W      = 8;
  localparam int DELAY_CYC   = 10;
  localparam int BURST_CNT_W = 16;
  localparam int LAT         = DELAY_CYC + 2;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  fifo_write_if #(.DATA_W(DATA_W), .BURST_CNT_W(BURST_CNT_W)) wif ();

  fifo_write #(
    .DATA_W      (DATA_W),
    .DELAY_CYC   (DELAY_CYC),
    .BURST_CNT_W (BURST_CNT_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr      (wif)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_data;
  int                exp_bursts;

`ifdef FIFO_WR_LFSR_EN
  localparam logic [7:0] RST_DATA = 8'h01;
  function automatic logic [7:0] pat_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
`else
  localparam logic [7:0] RST_DATA = 8'h00;
  function automatic logic [7:0] pat_next(input logic [7:0] v);
    return v + 8'd1;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst && wif.fifo_wr_en && !wif.full) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%0h, expected no write", wif.fifo_wdata);
      end else begin
        check("wdata", wif.fifo_wdata, exp_q.pop_front());
`ifdef FIFO_WR_LFSR_EN
        check("lfsr_nonzero", (wif.fifo_wdata != 8'h00), 1);
`endif
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, wif.fifo_wr_en, 0);
    check({tag, "_wdata"}, wif.fifo_wdata, RST_DATA);
    check({tag, "_burst_cnt"}, wif.wr_burst_cnt, 0);
    check({tag, "_busy"}, wif.wr_busy, 0);
  endtask

  // n accepted writes, ended by almost_full (on the n-th write) or by full
  // (held 4 cycles after the n-th write); toggle re-edges almost_empty in DELAY.
  task automatic run_burst(input int n, input bit end_full, input bit toggle);
    int cyc;
    wif.almost_empty = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_data);
      exp_data = pat_next(exp_data);
    end
    wif.almost_empty = 1'b1;
    cyc = 0;
    while (cyc < 40 && !wif.fifo_wr_en) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (toggle && cyc == 4) wif.almost_empty = 1'b0;
      if (toggle && cyc == 6) wif.almost_empty = 1'b1;
      if (cyc == 1) check("busy_before_delay", wif.wr_busy, 0);
      if (cyc == 2) check("busy_in_delay", wif.wr_busy, 1);
    end
    check("first_write_latency", cyc, LAT);

    if (end_full) begin
      repeat (n) @(posedge sys_clk);
      #1;
      wif.full = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge sys_clk);
        #1;
        check("wdata_hold_on_full", wif.fifo_wdata, exp_data);
        check("wr_en_off_on_full", wif.fifo_wr_en, 0);
      end
      wif.full = 1'b0;
    end else begin
      repeat (n - 1) @(posedge sys_clk);
      #1;
      wif.almost_full = 1'b1;
      @(posedge sys_clk);
      #1;
      wif.almost_full = 1'b0;
      check("wr_en_off_on_af", wif.fifo_wr_en, 0);
    end
    exp_bursts++;
    check("burst_cnt", wif.wr_burst_cnt, exp_bursts);
    check("busy_after_burst", wif.wr_busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    wif.almost_empty = 1'b1;
    wif.almost_full  = 1'b0;
    wif.full         = 1'b0;
    sys_rst          = 1'b1;
    exp_data         = RST_DATA;
    exp_bursts       = 0;

    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_values("reset");
    sys_rst = 1'b0;

    // almost_empty high through reset release is a level, not an edge.
    stray = 0;
    repeat (20) begin
      @(posedge sys_clk);
      #1;
      if (wif.fifo_wr_en || wif.wr_busy) stray++;
    end
    check("no_start_on_level", stray, 0);

    run_burst(32, 1'b1, 1'b0);
`ifndef FIFO_WR_LFSR_EN
    check("hold_value_20", wif.fifo_wdata, 8'h20);
`endif
    run_burst(100, 1'b0, 1'b1);
    run_burst(168, 1'b0, 1'b0);
`ifndef FIFO_WR_LFSR_EN
    check("after_300_writes", wif.fifo_wdata, 8'h2C);
`endif
    run_burst(1, 1'b0, 1'b0);

    // Reset asserted mid-burst after two accepted writes.
    wif.almost_empty = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_data);
      exp_data = pat_next(exp_data);
    end
    wif.almost_empty = 1'b1;
    repeat (LAT + 2) @(posedge sys_clk);
    #3;
    check("wr_en_before_mid_reset", wif.fifo_wr_en, 1);
    sys_rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    check("mid_reset_queue", exp_q.size(), 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst    = 1'b0;
    exp_data   = RST_DATA;
    exp_bursts = 0;
    run_burst(3, 1'b0, 1'b0);

    repeat (5) @(posedge sys_clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
